// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-SRAM responder: FSM state encoding
// and the byte-lane write-enable masks.
package dmem_responder_pkg;

  typedef enum logic [0:0] {
    DMEM_IDLE = 1'b0,
    DMEM_BUSY = 1'b1
  } dmem_state_e;

  localparam logic [3:0] WEN_NONE = 4'b0000;
  localparam logic [3:0] WEN_WORD = 4'b1111;

endpackage

// File: rtl/dmem_byte_bank.sv
// Single-port word array with four byte-lane write enables and a registered
// read port that holds its value unless a read is performed.
module dmem_byte_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [2**ADDR_WIDTH];

  // Byte-lane writes; array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'h0000_0000;
    end else if (re) begin
      rdata <= mem_r[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-SRAM responder: wait-state FSM with stall, request latch, range check
// and flush handling in front of a byte-lane word bank.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        flush,
  output logic [31:0] data_sram_rdata,
  output logic        data_ok,
  output logic        stall,
  output logic        addr_err
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_e           state_r, state_nxt_s;
  logic [CW-1:0]         cnt_r, cnt_nxt_s;
  logic [ADDR_WIDTH-1:0] lat_idx_r, req_idx_s, acc_idx_s;
  logic                  lat_oor_r, req_oor_s, acc_oor_s;
  logic [3:0]            lat_wen_r, acc_wen_s, bank_we_s;
  logic [31:0]           lat_wdata_r, acc_wdata_s;
  logic                  latch_s, fire_s, use_lat_s, bank_re_s, oor_hit_s;
  logic                  data_ok_r, addr_err_r;
  logic                  unused_addr_bits_s;

  assign req_idx_s          = data_sram_addr[ADDR_WIDTH+1:2];
  assign req_oor_s          = |data_sram_addr[31:ADDR_WIDTH+2];
  assign unused_addr_bits_s = ^data_sram_addr[1:0];

  // Next-state, counter and stall decode; flush always wins over an access.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall       = 1'b0;
    fire_s      = 1'b0;
    latch_s     = 1'b0;
    use_lat_s   = 1'b0;
    case (state_r)
      DMEM_IDLE: begin
        if (data_sram_en && !flush) begin
          if (WAIT_CYCLES == 0) begin
            fire_s = 1'b1;
          end else begin
            stall       = 1'b1;
            latch_s     = 1'b1;
            cnt_nxt_s   = CNT_LOAD;
            state_nxt_s = DMEM_BUSY;
          end
        end else begin
          state_nxt_s = DMEM_IDLE;
        end
      end
      DMEM_BUSY: begin
        use_lat_s = 1'b1;
        if (flush) begin
          state_nxt_s = DMEM_IDLE;
        end else if (cnt_r != '0) begin
          stall     = 1'b1;
          cnt_nxt_s = cnt_r - CW'(1);
        end else begin
          fire_s      = 1'b1;
          state_nxt_s = DMEM_IDLE;
        end
      end
      default: begin
        state_nxt_s = DMEM_IDLE;
      end
    endcase
  end

  assign acc_idx_s   = use_lat_s ? lat_idx_r   : req_idx_s;
  assign acc_oor_s   = use_lat_s ? lat_oor_r   : req_oor_s;
  assign acc_wen_s   = use_lat_s ? lat_wen_r   : data_sram_wen;
  assign acc_wdata_s = use_lat_s ? lat_wdata_r : data_sram_wdata;

  // A reset in the access cycle suppresses the access entirely.
  assign bank_we_s = (fire_s && !rst && !acc_oor_s) ? acc_wen_s : WEN_NONE;
  assign bank_re_s = fire_s && !rst && !acc_oor_s && (acc_wen_s == WEN_NONE);
  assign oor_hit_s = fire_s && acc_oor_s;

  // FSM state, wait counter and response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= DMEM_IDLE;
      cnt_r      <= '0;
      data_ok_r  <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      data_ok_r  <= bank_re_s;
      addr_err_r <= oor_hit_s;
    end
  end

  // Request capture held for the whole wait period.
  always_ff @(posedge clk) begin
    if (latch_s) begin
      lat_idx_r   <= req_idx_s;
      lat_oor_r   <= req_oor_s;
      lat_wen_r   <= data_sram_wen;
      lat_wdata_r <= data_sram_wdata;
    end
  end

  dmem_byte_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we_s),
    .re    (bank_re_s),
    .idx   (acc_idx_s),
    .wdata (acc_wdata_s),
    .rdata (data_sram_rdata)
  );

  assign data_ok  = data_ok_r;
  assign addr_err = addr_err_r;

endmodule
